// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, memory wait states, branch flush and HLT drain.
// Control outputs are combinational; state, drain count and perf counters are registered.
module hazard_ctrl #(
    parameter int unsigned REG_W        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic             fd_is_store,
    input  logic             fd_halt,
    input  logic             branch_taken,
    input  logic             dx_memread,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             dx_we,
    output logic             dx_bubble,
    output logic             xm_we,
    output logic             mw_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    state_e            state_q, state_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              dwait, loaduse, iwait;
    logic              stall_inc, flush_inc;

    assign dwait   = dmem_req & ~dmem_ready;
    assign iwait   = ~imem_ready;
    assign loaduse = dx_memread && (dx_rd != '0) &&
                     ((fd_uses_rs && (fd_rs == dx_rd)) ||
                      (fd_uses_rt && !fd_is_store && (fd_rt == dx_rd)));

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_we     = 1'b1;
        dx_bubble = 1'b0;
        xm_we     = 1'b1;
        mw_bubble = 1'b0;
        halted    = 1'b0;
        state_d   = state_q;
        drain_d   = drain_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (rst) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            xm_we     = 1'b0;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            mw_bubble = 1'b1;
            state_d   = RUN;
            drain_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dwait) begin
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        dx_we     = 1'b0;
                        xm_we     = 1'b0;
                        mw_bubble = 1'b1;
                        stall_inc = 1'b1;
                    end else if (loaduse || iwait) begin
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        dx_bubble = 1'b1;
                        stall_inc = 1'b1;
                    end else if (branch_taken) begin
                        fd_flush  = 1'b1;
                        flush_inc = 1'b1;
                    end else if (fd_halt) begin
                        pc_we    = 1'b0;
                        fd_flush = 1'b1;
                        state_d  = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                        drain_d  = DC_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    pc_we     = 1'b0;
                    fd_flush  = 1'b1;
                    dx_bubble = 1'b1;
                    if (dwait) begin
                        fd_we     = 1'b0;
                        dx_we     = 1'b0;
                        xm_we     = 1'b0;
                        mw_bubble = 1'b1;
                        stall_inc = 1'b1;
                    end else if (drain_q == DC_W'(1)) begin
                        state_d = HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DC_W'(1);
                    end
                end
                HALTED: begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_we     = 1'b0;
                    mw_bubble = 1'b1;
                    halted    = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
